// File: rtl/mwg_pkg.sv
// Shared types, constants and phase decode for the multiphase waveform generator.
package mwg_pkg;

    typedef enum logic [1:0] {
        MODE_TRI  = 2'd0,
        MODE_SINE = 2'd1,
        MODE_SAW  = 2'd2,
        MODE_SQR  = 2'd3
    } mode_e;

    localparam int unsigned WAVE_W   = 16;
    localparam int unsigned AMP_W    = 16;
    localparam logic [AMP_W-1:0] Q15_ONE = 16'h8000;
    localparam int unsigned AMP_FRAC = $clog2(Q15_ONE);
    localparam int          SAT_MAX  = 32767;
    localparam int          SAT_MIN  = -32767;

    typedef logic signed [WAVE_W-1:0] sample_t;

    typedef struct packed {
        logic [1:0]  quad;
        logic [13:0] frac;
    } phase_dec_t;

    function automatic phase_dec_t quad_decode(input logic [15:0] phase);
        phase_dec_t d;
        d.quad = phase[15:14];
        d.frac = phase[13:0];
        return d;
    endfunction

endpackage

// File: rtl/quarter_sine_rom.sv
// Quarter-wave sine table with one registered read port; entries are sampled at
// bin centres so that the ~addr mirroring of odd quadrants is exactly symmetric.
module quarter_sine_rom
    import mwg_pkg::*;
#(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] rd_data
);

    localparam int unsigned DEPTH = 1 << ADDR_W;

    function automatic logic [DATA_W-1:0] sine_entry(input int unsigned idx);
        real theta;
        theta = 3.141592653589793 * (real'(idx) + 0.5) / real'(2 * DEPTH);
        return DATA_W'($rtoi(real'(SAT_MAX) * $sin(theta) + 0.5));
    endfunction

    logic [DATA_W-1:0] table_c [DEPTH];
    logic [DATA_W-1:0] data_q, data_d;

    for (genvar a = 0; a < DEPTH; a++) begin : g_tab
        assign table_c[a] = sine_entry(a);
    end

    always_comb begin
        data_d = table_c[addr];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) data_q <= '0;
        else        data_q <= data_d;
    end

    assign rd_data = data_q;

endmodule

// File: rtl/multiphase_wave_gen.sv
// NCH-channel phase-offset waveform generator: shared accumulator, per-channel
// shaping, Q1.15 gain with saturation, 4-stage pipeline to a valid-qualified output.
module multiphase_wave_gen
    import mwg_pkg::*;
#(
    parameter int unsigned NCH           = 3,
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned PHASE_W       = 16,
    parameter int unsigned LUT_ADDR_W    = 10,
    parameter int unsigned PHASE_SPACING = 10923
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  tick,
    input  logic                  phase_clr,
    input  logic [PHASE_W-1:0]    freq_word,
    input  logic [1:0]            mode,
    input  logic [15:0]           amp,
    output logic [NCH*DATA_W-1:0] out_data,
    output logic                  out_valid
);

    localparam int unsigned PROD_W = WAVE_W + AMP_W + 1;
    localparam int unsigned Y_W    = PROD_W - AMP_FRAC;

    localparam sample_t             S_POS = WAVE_W'(SAT_MAX);
    localparam sample_t             S_NEG = WAVE_W'(SAT_MIN);
    localparam logic signed [Y_W-1:0] Y_POS = Y_W'(SAT_MAX);
    localparam logic signed [Y_W-1:0] Y_NEG = Y_W'(SAT_MIN);

    // Non-sine shapes; sine comes from the ROM one stage later.
    function automatic sample_t shape_wave(input mode_e m, input logic [PHASE_W-1:0] p);
        phase_dec_t d;
        sample_t    ramp;
        sample_t    w;
        d    = quad_decode(p);
        ramp = $signed({1'b0, d.frac, 1'b0});
        w    = '0;
        case (m)
            MODE_TRI: begin
                case (d.quad)
                    2'd0:    w = ramp;
                    2'd1:    w = S_POS - ramp;
                    2'd2:    w = -ramp;
                    default: w = S_NEG + ramp;
                endcase
            end
            MODE_SAW: w = $signed({~p[15], p[14:0]});
            MODE_SQR: w = d.quad[1] ? S_NEG : S_POS;
            default:  w = '0;
        endcase
        return w;
    endfunction

    logic                  tick_ok_c;
    logic [PHASE_W-1:0]    acc_q, acc_d;

    logic                  s1_vld_q, s1_vld_d;
    mode_e                 s1_mode_q, s1_mode_d;
    logic [AMP_W-1:0]      s1_amp_q, s1_amp_d;
    logic [PHASE_W-1:0]    s1_phase_q [NCH];
    logic [PHASE_W-1:0]    s1_phase_d [NCH];

    logic [LUT_ADDR_W-1:0] rom_addr_c [NCH];
    logic [WAVE_W-1:0]     rom_data_c [NCH];

    logic                  s2_vld_q, s2_vld_d;
    mode_e                 s2_mode_q, s2_mode_d;
    logic [AMP_W-1:0]      s2_amp_q, s2_amp_d;
    sample_t               s2_wave_q [NCH];
    sample_t               s2_wave_d [NCH];
    logic [NCH-1:0]        s2_neg_q, s2_neg_d;

    sample_t               w_c    [NCH];
    logic signed [PROD_W-1:0] prod_c [NCH];
    logic                  s3_vld_q, s3_vld_d;
    logic signed [Y_W-1:0] s3_y_q [NCH];
    logic signed [Y_W-1:0] s3_y_d [NCH];

    sample_t               sat_c [NCH];
    logic [NCH*DATA_W-1:0] out_data_q, out_data_d;
    logic                  out_valid_q, out_valid_d;

    assign tick_ok_c = tick & en;

    // Accumulator and stage 1: capture channel phases with the pre-update acc.
    always_comb begin
        acc_d     = acc_q;
        s1_vld_d  = tick_ok_c;
        s1_mode_d = s1_mode_q;
        s1_amp_d  = s1_amp_q;
        for (int k = 0; k < NCH; k++) s1_phase_d[k] = s1_phase_q[k];
        if (phase_clr)      acc_d = '0;
        else if (tick_ok_c) acc_d = acc_q + freq_word;
        if (tick_ok_c) begin
            s1_mode_d = mode_e'(mode);
            s1_amp_d  = amp;
            for (int k = 0; k < NCH; k++)
                s1_phase_d[k] = acc_q - PHASE_W'(k * PHASE_SPACING);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            s1_vld_q  <= 1'b0;
            s1_mode_q <= MODE_TRI;
            s1_amp_q  <= '0;
            for (int k = 0; k < NCH; k++) s1_phase_q[k] <= '0;
        end else begin
            acc_q     <= acc_d;
            s1_vld_q  <= s1_vld_d;
            s1_mode_q <= s1_mode_d;
            s1_amp_q  <= s1_amp_d;
            for (int k = 0; k < NCH; k++) s1_phase_q[k] <= s1_phase_d[k];
        end
    end

    // ROM address mirrors within odd quadrants.
    always_comb begin
        for (int k = 0; k < NCH; k++)
            rom_addr_c[k] = s1_phase_q[k][13 -: LUT_ADDR_W] ^ {LUT_ADDR_W{s1_phase_q[k][14]}};
    end

    for (genvar k = 0; k < NCH; k++) begin : g_rom
        quarter_sine_rom #(
            .ADDR_W (LUT_ADDR_W),
            .DATA_W (WAVE_W)
        ) u_rom (
            .clk     (clk),
            .rst_n   (rst_n),
            .addr    (rom_addr_c[k]),
            .rd_data (rom_data_c[k])
        );
    end

    always_comb begin
        s2_vld_d  = s1_vld_q;
        s2_mode_d = s2_mode_q;
        s2_amp_d  = s2_amp_q;
        s2_neg_d  = s2_neg_q;
        for (int k = 0; k < NCH; k++) s2_wave_d[k] = s2_wave_q[k];
        if (s1_vld_q) begin
            s2_mode_d = s1_mode_q;
            s2_amp_d  = s1_amp_q;
            for (int k = 0; k < NCH; k++) begin
                s2_wave_d[k] = shape_wave(s1_mode_q, s1_phase_q[k]);
                s2_neg_d[k]  = s1_phase_q[k][15];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_vld_q  <= 1'b0;
            s2_mode_q <= MODE_TRI;
            s2_amp_q  <= '0;
            s2_neg_q  <= '0;
            for (int k = 0; k < NCH; k++) s2_wave_q[k] <= '0;
        end else begin
            s2_vld_q  <= s2_vld_d;
            s2_mode_q <= s2_mode_d;
            s2_amp_q  <= s2_amp_d;
            s2_neg_q  <= s2_neg_d;
            for (int k = 0; k < NCH; k++) s2_wave_q[k] <= s2_wave_d[k];
        end
    end

    // Stage 3: apply sine sign, multiply by unsigned gain, floor-shift back to Q0.
    always_comb begin
        s3_vld_d = s2_vld_q;
        for (int k = 0; k < NCH; k++) begin
            if (s2_mode_q == MODE_SINE)
                w_c[k] = s2_neg_q[k] ? -sample_t'(rom_data_c[k]) : sample_t'(rom_data_c[k]);
            else
                w_c[k] = s2_wave_q[k];
            prod_c[k] = PROD_W'(w_c[k]) * PROD_W'($signed({1'b0, s2_amp_q}));
            s3_y_d[k] = s2_vld_q ? Y_W'(prod_c[k] >>> AMP_FRAC) : s3_y_q[k];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s3_vld_q <= 1'b0;
            for (int k = 0; k < NCH; k++) s3_y_q[k] <= '0;
        end else begin
            s3_vld_q <= s3_vld_d;
            for (int k = 0; k < NCH; k++) s3_y_q[k] <= s3_y_d[k];
        end
    end

    // Stage 4: symmetric clamp, truncate to DATA_W, hold until next valid.
    always_comb begin
        out_valid_d = s3_vld_q;
        out_data_d  = out_data_q;
        for (int k = 0; k < NCH; k++) begin
            if (s3_y_q[k] > Y_POS)      sat_c[k] = S_POS;
            else if (s3_y_q[k] < Y_NEG) sat_c[k] = S_NEG;
            else                        sat_c[k] = WAVE_W'(s3_y_q[k]);
            if (s3_vld_q)
                out_data_d[k*DATA_W +: DATA_W] = DATA_W'(sat_c[k] >>> (WAVE_W - DATA_W));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_multiphase_wave_gen.sv
// Scoreboard bench for multiphase_wave_gen: stimulus pushes model samples,
// a posedge+1 monitor pops and compares every out_valid and checks hold otherwise.
`timescale 1ns/1ps
module tb_multiphase_wave_gen;

    localparam int NCH    = 3;
    localparam int DATA_W = 16;
    localparam int LUT_AW = 10;
    localparam int DEPTH  = 1 << LUT_AW;
    localparam int SP     = 10923;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b1;
    logic                  en = 1'b0;
    logic                  tick = 1'b0;
    logic                  phase_clr = 1'b0;
    logic [15:0]           freq_word = '0;
    logic [1:0]            mode = '0;
    logic [15:0]           amp = '0;
    logic [NCH*DATA_W-1:0] out_data;
    logic                  out_valid;

    multiphase_wave_gen #(
        .NCH(NCH), .DATA_W(DATA_W), .PHASE_W(16), .LUT_ADDR_W(LUT_AW), .PHASE_SPACING(SP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .tick(tick), .phase_clr(phase_clr),
        .freq_word(freq_word), .mode(mode), .amp(amp),
        .out_data(out_data), .out_valid(out_valid)
    );

    always #5 clk = ~clk;

    typedef logic [NCH-1:0][DATA_W-1:0] vec_t;
    typedef struct packed {
        vec_t           val;
        logic [NCH-1:0] den;
        vec_t           dir;
        logic [31:0]    cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    int          sine_tbl[DEPTH];
    logic [15:0] m_acc = '0;
    vec_t        last = '0;

    function automatic int wave_of(input int m, input int p);
        int q, f, idx, v;
        q = p / 16384;
        f = p % 16384;
        case (m)
            0: begin
                if (q == 0)      return 2 * f;
                else if (q == 1) return 32767 - 2 * f;
                else if (q == 2) return -2 * f;
                else             return -32767 + 2 * f;
            end
            1: begin
                idx = f / (16384 / DEPTH);
                if (q % 2 == 1) idx = DEPTH - 1 - idx;
                v = sine_tbl[idx];
                return (q >= 2) ? -v : v;
            end
            2: return p - 32768;
            default: return (p < 32768) ? 32767 : -32767;
        endcase
    endfunction

    function automatic int scale_of(input int w, input int a);
        longint prod, y;
        prod = longint'(w) * longint'(a);
        y = prod >>> 15;
        if (y > 32767)  y = 32767;
        if (y < -32767) y = -32767;
        return int'(y >>> (16 - DATA_W));
    endfunction

    function automatic vec_t model_vec(input logic [15:0] acc, input int m, input int a);
        vec_t v;
        int   p;
        for (int k = 0; k < NCH; k++) begin
            p = (int'(acc) - k * SP) & 32'hFFFF;
            v[k] = DATA_W'(scale_of(wave_of(m, p), a));
        end
        return v;
    endfunction

    task automatic step(input bit t, input bit e, input bit c, input logic [15:0] fw,
                        input logic [1:0] m, input logic [15:0] a, input logic [NCH-1:0] den,
                        input int d0, input int d1, input int d2);
        exp_t x;
        tick = t; en = e; phase_clr = c; freq_word = fw; mode = m; amp = a;
        if (t && e) begin
            x.val    = model_vec(m_acc, int'(m), int'(a));
            x.den    = den;
            x.dir[0] = DATA_W'(d0);
            x.dir[1] = DATA_W'(d1);
            x.dir[2] = DATA_W'(d2);
            x.cyc    = 32'(cyc);
            exp_q.push_back(x);
        end
        if (c)           m_acc = '0;
        else if (t && e) m_acc = m_acc + fw;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 16'h0, 2'd0, 16'h0, '0, 0, 0, 0);
    endtask

    task automatic do_reset();
        tick = 0; en = 0; phase_clr = 0;
        rst_n = 1'b0;
        exp_q.delete();
        m_acc = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: pop on every valid, otherwise out_data must hold its last value.
    always @(posedge clk) begin
        exp_t x;
        int   got;
        #1;
        if (!rst_n) last = '0;
        if (out_valid) begin
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL spurious_valid: out_valid=1 with no sample pending, out_data=%h", out_data);
            end else begin
                x = exp_q.pop_front();
                if (cyc - int'(x.cyc) != 4) begin
                    bad++;
                    $display("FAIL latency: got %0d cycles want 4", cyc - int'(x.cyc));
                end
                for (int k = 0; k < NCH; k++) begin
                    got = $signed(out_data[k*DATA_W +: DATA_W]);
                    total++;
                    if (got != int'($signed(x.val[k]))) begin
                        bad++;
                        $display("FAIL sample ch%0d: got %0d want %0d", k, got, $signed(x.val[k]));
                    end
                    if (x.den[k]) begin
                        total++;
                        if (got != int'($signed(x.dir[k]))) begin
                            bad++;
                            $display("FAIL directed ch%0d: got %0d want %0d", k, got, $signed(x.dir[k]));
                        end
                    end
                end
                last = x.val;
            end
        end else begin
            total++;
            if (out_data !== last) begin
                bad++;
                $display("FAIL hold: out_data=%h want %h", out_data, last);
            end
        end
    end

    initial begin
        logic [15:0] a;
        int l0, lm;
        for (int i = 0; i < DEPTH; i++)
            sine_tbl[i] = $rtoi(32767.0 * $sin(3.141592653589793 * (real'(i) + 0.5) / real'(2 * DEPTH)) + 0.5);
        l0 = sine_tbl[0];
        lm = sine_tbl[DEPTH-1];

        #1 rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0 || out_data !== '0) begin
            bad++;
            $display("FAIL reset_state: valid=%b data=%h want 0/0", out_valid, out_data);
        end
        rst_n = 1'b1;
        @(negedge clk);

        // Ticks with en=0 are ignored and leave acc at 0.
        for (int i = 0; i < 5; i++) step(1, 0, 0, 16'h1234, 2'd1, 16'h8000, '0, 0, 0, 0);
        idle(6);
        step(1, 1, 0, 16'h0, 2'd0, 16'h8000, 3'b111, 0, -21845, -21844);
        idle(6);

        // Sine quadrant walk and wrap back to phase 0.
        step(0, 0, 1, 16'h0, 2'd0, 16'h0, '0, 0, 0, 0);
        step(1, 1, 0, 16'h4000, 2'd1, 16'h8000, 3'b001, l0, 0, 0);
        step(1, 1, 0, 16'h4000, 2'd1, 16'h8000, 3'b001, lm, 0, 0);
        step(1, 1, 0, 16'h4000, 2'd1, 16'h8000, 3'b001, -l0, 0, 0);
        step(1, 1, 0, 16'h4000, 2'd1, 16'h8000, 3'b001, -lm, 0, 0);
        step(1, 1, 0, 16'h0, 2'd1, 16'h8000, 3'b001, l0, 0, 0);
        idle(6);

        // Saturation corners and half gain.
        step(0, 0, 1, 16'h0, 2'd0, 16'h0, '0, 0, 0, 0);
        step(1, 1, 0, 16'h0, 2'd2, 16'h8000, 3'b001, -32767, 0, 0);
        step(1, 1, 0, 16'h0, 2'd3, 16'hFFFF, 3'b111, 32767, -32767, -32767);
        step(0, 0, 1, 16'h0, 2'd0, 16'h0, '0, 0, 0, 0);
        step(1, 1, 0, 16'h5000, 2'd0, 16'h8000, '0, 0, 0, 0);
        step(1, 1, 0, 16'h0, 2'd0, 16'h4000, 3'b111, 12287, 9557, -1366);
        idle(6);

        // Back-to-back ticks with mode switching every cycle.
        for (int i = 0; i < 16; i++)
            step(1, 1, 0, 16'($urandom), 2'(i % 4), 16'($urandom), '0, 0, 0, 0);
        idle(6);

        // Reset while a sample is in flight.
        step(1, 1, 0, 16'h1111, 2'd1, 16'h8000, '0, 0, 0, 0);
        idle(1);
        do_reset();
        idle(6);

        // phase_clr with tick samples the old phase; next sample is at phase 0.
        step(1, 1, 0, 16'h3000, 2'd2, 16'h8000, '0, 0, 0, 0);
        step(1, 1, 1, 16'h1000, 2'd0, 16'h8000, '0, 0, 0, 0);
        step(1, 1, 0, 16'h0, 2'd0, 16'h8000, 3'b001, 0, 0, 0);
        idle(6);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom % 4)
                0:       a = 16'hFFFF;
                1:       a = 16'h8000;
                2:       a = 16'h0000;
                default: a = 16'($urandom);
            endcase
            if ($urandom % 100 == 0) do_reset();
            step(($urandom % 3) != 0, ($urandom % 4) != 0, ($urandom % 16) == 0,
                 16'($urandom), 2'($urandom), a, '0, 0, 0, 0);
        end
        idle(10);

        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL missing_valid: %0d samples never produced, want 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
